// File: rtl/change_logger_if.sv
// change_logger_if
//   Groups the monitored-bus inputs and the event-FIFO read side of
//   change_logger into one bundle.
//
//   Signals
//     din        producer -> logger   monitored value
//     en         producer -> logger   logging enable
//     clear      producer -> logger   clears the sticky overflow flag
//     out_ready  consumer -> logger   consumer accepts the head entry
//     out_valid  logger -> consumer   FIFO non-empty, head entry presented
//     out_data   logger -> consumer   logged value of the head entry
//     out_ts     logger -> consumer   timestamp of the head entry
//     level      logger -> consumer   number of stored entries
//     overflow   logger -> consumer   sticky flag, an event was dropped
//
//   Modports
//     slave   the logger side (change_logger)
//     master  the environment side (producer + consumer)
interface change_logger_if #(
    parameter int DATA_W = 3,
    parameter int DEPTH  = 4,
    parameter int TS_W   = 8
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] din;
    logic              en;
    logic              clear;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [TS_W-1:0]   out_ts;
    logic [LVL_W-1:0]  level;
    logic              overflow;

    modport slave (
        input  din,
        input  en,
        input  clear,
        input  out_ready,
        output out_valid,
        output out_data,
        output out_ts,
        output level,
        output overflow
    );

    modport master (
        output din,
        output en,
        output clear,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  out_ts,
        input  level,
        input  overflow
    );
endinterface

// File: rtl/change_logger.sv
// change_logger
//   Watches a DATA_W-wide bus and, whenever it changes while logging is
//   enabled, stores {new value, timestamp} in a small FIFO. The timestamp
//   is a free-running TS_W-bit cycle counter; the value recorded is the
//   counter as it stood just before the edge that saw the change.
//   When the FIFO is full and nothing is popped on the same edge, the
//   event is dropped and a sticky overflow flag is raised.
//
//   Ports
//     clk    single clock, all state on the rising edge
//     rst_n  asynchronous active-low reset
//     bus    change_logger_if.slave (din/en/clear/out_ready in;
//            out_valid/out_data/out_ts/level/overflow out)
//
//   DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module change_logger #(
    parameter int DATA_W = 3,
    parameter int DEPTH  = 4,
    parameter int TS_W   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    change_logger_if.slave  bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;
    localparam int ENT_W = DATA_W + TS_W;

    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] prev;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic [ENT_W-1:0]  mem [DEPTH];

    logic              change;
    logic              full;
    logic              not_empty;
    logic              pop;
    logic              push;
    logic              drop;
    logic [ENT_W-1:0]  head;

    assign change    = bus.en && (bus.din != prev);
    assign not_empty = (level != '0);
    assign full      = (level == LVL_W'(DEPTH));
    assign pop       = not_empty && bus.out_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push      = change && (!full || pop);
    assign drop      = change && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts       <= '0;
            prev     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            ts   <= ts + TS_W'(1);
            prev <= bus.din;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            // Set has priority over clear so a drop is never lost.
            if (drop) begin
                overflow <= 1'b1;
            end else if (bus.clear) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.din, ts};
        end
    end

    assign head = mem[rd_ptr];

    assign bus.out_valid = not_empty;
    assign bus.out_data  = not_empty ? head[TS_W +: DATA_W] : '0;
    assign bus.out_ts    = not_empty ? head[TS_W-1:0]       : '0;
    assign bus.level     = level;
    assign bus.overflow  = overflow;
endmodule

// File: tb/tb_change_logger.sv
module tb_change_logger;
    localparam int DATA_W = 3;
    localparam int DEPTH  = 4;
    localparam int TS_W   = 8;

    logic clk;
    logic rst_n;

    change_logger_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)) bus ();

    change_logger #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DATA_W+TS_W-1:0] sb [$];
    logic [TS_W-1:0]        tb_ts;
    logic [TS_W-1:0]        first_ts;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle reference: value the DUT timestamp should hold right now.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_ts <= '0;
        else        tb_ts <= tb_ts + 8'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Drive a new din value for the next edge; optionally expect it logged.
    task automatic change(input logic [DATA_W-1:0] v, input bit expect_push);
        bus.din = v;
        if (expect_push) sb.push_back({v, tb_ts});
        step();
    endtask

    // Monitor: a pop happens at the next edge whenever valid && ready here.
    initial begin
        logic [DATA_W+TS_W-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_entry", {21'd0, bus.out_data, bus.out_ts}, 32'hffff_ffff);
                end else begin
                    e = sb.pop_front();
                    chk("entry", {21'd0, bus.out_data, bus.out_ts}, {21'd0, e});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b1;
        bus.din       = '0;
        bus.en        = 1'b0;
        bus.clear     = 1'b0;
        bus.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid",    bus.out_valid, 0);
        chk("rst_level",    bus.level,     0);
        chk("rst_overflow", bus.overflow,  0);
        chk("rst_data",     bus.out_data,  0);
        chk("rst_ts",       bus.out_ts,    0);

        @(negedge clk);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.en        = 1'b1;
        bus.out_ready = 1'b1;

        // Constant input: nothing logged.
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle", {bus.out_valid, bus.level, bus.overflow}, 0);
        end

        // Single change sampled at ts=5 (after the counter wraps once).
        for (int i = 0; i < 300 && tb_ts != 8'd5; i++) step();
        change(3'b011, 1);
        chk("single_valid", bus.out_valid, 1);
        chk("single_data",  bus.out_data,  3);
        chk("single_ts",    bus.out_ts,    5);
        chk("single_level", bus.level,     1);
        step();
        chk("single_drained", bus.level, 0);

        // Timestamp wrap: changes at ts=255 and the following edge.
        for (int i = 0; i < 300 && tb_ts != 8'hff; i++) step();
        change(3'b100, 1);
        chk("wrap_ts255", bus.out_ts, 8'hff);
        change(3'b010, 1);
        chk("wrap_ts0",   bus.out_ts, 0);
        chk("wrap_data",  bus.out_data, 2);
        step();
        chk("wrap_drained", bus.level, 0);

        // Overflow: five changes with no consumer, last one dropped.
        bus.out_ready = 1'b0;
        first_ts = tb_ts;
        change(3'b001, 1);
        change(3'b010, 1);
        change(3'b011, 1);
        change(3'b100, 1);
        change(3'b101, 0);
        chk("ovf_level", bus.level,    4);
        chk("ovf_flag",  bus.overflow, 1);
        chk("hold_data", bus.out_data, 1);
        chk("hold_ts",   bus.out_ts,   first_ts);
        step();
        chk("hold_data2", bus.out_data, 1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("ovf_drained", bus.level,    0);
        chk("ovf_sticky",  bus.overflow, 1);
        chk("ready_empty", bus.out_valid, 0);
        bus.out_ready = 1'b0;
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        chk("ovf_cleared", bus.overflow, 0);

        // Drop and clear on the same edge: set wins.
        change(3'b110, 1);
        change(3'b111, 1);
        change(3'b110, 1);
        change(3'b111, 1);
        bus.clear = 1'b1;
        change(3'b000, 0);
        bus.clear = 1'b0;
        chk("setwins_flag",  bus.overflow, 1);
        chk("setwins_level", bus.level,    4);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        chk("setwins_clear", bus.overflow, 0);

        // Full FIFO, push and pop on the same edge.
        bus.out_ready = 1'b1;
        change(3'b101, 1);
        chk("fullpp_level", bus.level,    4);
        chk("fullpp_flag",  bus.overflow, 0);
        for (int i = 0; i < 4; i++) step();
        chk("fullpp_drained", bus.level, 0);

        // Reset mid-operation with three entries stored.
        bus.out_ready = 1'b0;
        change(3'b001, 1);
        change(3'b010, 1);
        change(3'b011, 1);
        chk("pre_rst_level", bus.level, 3);
        #1 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_valid", bus.out_valid, 0);
        chk("midrst_level", bus.level,     0);
        chk("midrst_data",  bus.out_data,  0);
        rst_n = 1'b1;
        // din=011 differs from the reset value of prev: logged at ts=0.
        sb.push_back({3'b011, 8'd0});
        step();
        chk("post_rst_level", bus.level,    1);
        chk("post_rst_data",  bus.out_data, 3);
        chk("post_rst_ts",    bus.out_ts,   0);

        // en=0 blocks new events but the stored entry stays readable.
        bus.en        = 1'b0;
        bus.din       = 3'b000;
        bus.out_ready = 1'b1;
        step();
        step();
        chk("en0_level", bus.level, 0);
        step();
        chk("en0_quiet", bus.out_valid, 0);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/change_logger.md
CHANGE_LOGGER -- requirements
Module: change_logger

Interface
REQ-001 The block SHALL have parameter DATA_W, default 3, width of the monitored bus.
REQ-002 The block SHALL have parameter DEPTH, default 4, event FIFO entries (power of two, >=2).
REQ-003 The block SHALL have parameter TS_W, default 8, timestamp width.
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 The block SHALL have port din  input  DATA_W  monitored value, synchronous to clk.
REQ-007 The block SHALL have port en  input  1  logging enable.
REQ-008 The block SHALL have port clear  input  1  clears the overflow flag.
REQ-009 The block SHALL have port out_ready  input  1  consumer accepts the head entry.
REQ-010 The block SHALL have port out_valid  output  1  FIFO non-empty; head entry presented.
REQ-011 The block SHALL have port out_data  output  DATA_W  logged value of the head entry.
REQ-012 The block SHALL have port out_ts  output  TS_W  timestamp of the head entry.
REQ-013 The block SHALL have port level  output  clog2(DEPTH)+1  number of stored entries.
REQ-014 The block SHALL have port overflow  output  1  sticky flag; an event was dropped.

Function
REQ-015 Free-running counter ts SHALL increment by 1 every cycle and wrap from 2^TS_W-1 to 0.
REQ-016 Register prev SHALL load din every cycle, regardless of en.
REQ-017 Change event at an edge SHALL be: en=1 and din != prev, both sampled at that edge.
REQ-018 On a change event with FIFO not full, the block SHALL write {din, ts} at that edge, where ts is the counter value before the edge.
REQ-019 The written entry SHALL be visible on the outputs no earlier than the cycle after the write edge; there is no bypass.
REQ-020 On a change event with FIFO full and no pop at the same edge, the event SHALL be dropped and overflow set.
REQ-021 Pop SHALL occur at an edge where out_valid=1 and out_ready=1.
REQ-022 out_ready while out_valid=0 SHALL have no effect.
REQ-023 While out_valid=1 and out_ready=0, out_data and out_ts SHALL hold stable.
REQ-024 Simultaneous push and pop SHALL leave level unchanged; this includes the full case, where the push is accepted with no overflow.
REQ-025 Entries SHALL leave in write order (FIFO).
REQ-026 Read and write pointers SHALL wrap modulo DEPTH.
REQ-027 level SHALL always equal writes minus pops; out_valid SHALL equal (level != 0).
REQ-028 overflow SHALL remain set until clear=1.
REQ-029 If clear=1 and a drop occur at the same edge, overflow SHALL be 1 (set wins).
REQ-030 en=0 SHALL suppress new events only; stored entries SHALL remain readable.

Reset
REQ-031 rst_n=0 SHALL immediately, without waiting for a clock, force these values: ts=0, prev=0, FIFO pointers=0, level=0, out_valid=0, overflow=0.
REQ-032 out_data and out_ts SHALL read 0 while the FIFO is empty after reset.
REQ-033 Reset asserted mid-operation SHALL discard all stored entries.
REQ-034 The first edge after rst_n deasserts SHALL be an ordinary cycle: ts 0 -> 1, and a change is detected if din != 0.

Verification (DATA_W=3, DEPTH=4, TS_W=8)
REQ-035 Hold din=000, en=1 for 10 cycles after reset -> out_valid=0, level=0, overflow=0 throughout.
REQ-036 din goes 000->011, first sampled at the edge with ts=5, out_ready=1 -> next cycle out_valid=1, out_data=011, out_ts=5; entry popped at the following edge; level returns to 0.
REQ-037 out_ready=0; five changes 001,010,011,100,101 -> level=4, overflow=1, 101 dropped; drain yields 001,010,011,100 in order; a clear pulse then sets overflow=0.
REQ-038 Changes sampled at ts=255 and at the next edge -> entries record out_ts=255 then 0.
REQ-039 FIFO full, change and pop at the same edge -> level stays 4, overflow stays 0, new entry becomes the tail.
REQ-040 3 entries stored; rst_n pulsed low between edges -> out_valid=0 and level=0 before the next edge; no stale entries after release.
